// File: rtl/bcd_seven_seg_driver_if.sv
// Digit-pair input and display-drive bundle for the two-digit seven-segment driver.
// The converter side drives tens/ones; the driver side produces the segment, anode and update signals.
interface bcd_seven_seg_driver_if;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [6:0] seg;
   logic [1:0] an;
   logic       disp_update;
   logic       scan_dbg;

   // tens/ones are level inputs sampled every clock; there is no valid/ready pairing on this bus,
   // and a pair is accepted purely by holding it steady long enough.
   modport master (output ones, tens, input seg, an, disp_update, scan_dbg);
   modport slave  (input ones, tens, output seg, an, disp_update, scan_dbg);
endinterface

// File: rtl/bcd_seven_seg_driver.sv
// Stability-filtered two-digit BCD display driver with time-multiplexed common-anode scan.
// scan_dbg exposes the scan FSM state (0 = ones slot, 1 = tens slot).
module bcd_seven_seg_driver #(
   parameter int unsigned REFRESH_DIV    = 4,
   parameter int unsigned STABLE_CYCLES  = 3,
   parameter bit          BLANK_LZ       = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   bcd_seven_seg_driver_if.slave  bus
);

   typedef enum logic {S_ONES = 1'b0, S_TENS = 1'b1} scan_t;

   localparam logic [15:0] RCNT_LAST = 16'(REFRESH_DIV - 1);
   localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
   localparam logic [6:0]  SEG_MASK  = {7{SEG_ACTIVE_LOW}};

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   scan_t       state, state_n;
   logic [15:0] rcnt, rcnt_n;
   logic [7:0]  cand;
   logic [7:0]  stab_cnt;
   logic [7:0]  disp, disp_n;
   logic [7:0]  pair_in;
   logic        accept;
   logic [3:0]  digit;
   logic [6:0]  seg_hi;
   logic [1:0]  an_n;
   logic [6:0]  seg_q;
   logic [1:0]  an_q;
   logic        disp_update_q;

   // Outputs are built from next-state scan and display values so seg never lags an.
   always_comb begin
      pair_in = {bus.tens, bus.ones};
      accept  = (pair_in == cand) && (stab_cnt == STAB_LAST) && (cand != disp);
      disp_n  = accept ? cand : disp;

      state_n = state;
      rcnt_n  = rcnt + 16'd1;
      if (rcnt == RCNT_LAST) begin
         rcnt_n  = 16'd0;
         state_n = (state == S_ONES) ? S_TENS : S_ONES;
      end

      digit  = (state_n == S_TENS) ? disp_n[7:4] : disp_n[3:0];
      seg_hi = decode(digit);
      if (BLANK_LZ && (state_n == S_TENS) && (disp_n[7:4] == 4'd0))
         seg_hi = 7'h00;
      an_n = (state_n == S_TENS) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_ONES;
         rcnt          <= 16'd0;
         cand          <= 8'd0;
         stab_cnt      <= 8'd0;
         disp          <= 8'd0;
         disp_update_q <= 1'b0;
         an_q          <= 2'b10;
         seg_q         <= 7'h3F ^ SEG_MASK;
      end else begin
         if (pair_in != cand) begin
            cand     <= pair_in;
            stab_cnt <= 8'd0;
         end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
         disp          <= disp_n;
         disp_update_q <= accept;
         state         <= state_n;
         rcnt          <= rcnt_n;
         an_q          <= an_n;
         seg_q         <= seg_hi ^ SEG_MASK;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.an          = an_q;
   assign bus.disp_update = disp_update_q;
   assign bus.scan_dbg    = state;

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// Directed bench for bcd_seven_seg_driver: default instance (a) plus a
// REFRESH_DIV=1 / STABLE_CYCLES=1 / BLANK_LZ=0 instance (b) sharing the same digit stimulus.
module tb_bcd_seven_seg_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   scan_k = 0;

   always #5 clk = ~clk;

   // Edges since the last reset edge; gives the expected scan slot independently of the DUT.
   always @(posedge clk) begin
      if (rst) scan_k <= 0;
      else     scan_k <= scan_k + 1;
   end

   bcd_seven_seg_driver_if if_a ();
   bcd_seven_seg_driver_if if_b ();

   bcd_seven_seg_driver u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   bcd_seven_seg_driver #(
      .REFRESH_DIV    (1),
      .STABLE_CYCLES  (1),
      .BLANK_LZ       (1'b0),
      .SEG_ACTIVE_LOW (1'b1)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pair(input logic [3:0] t, input logic [3:0] o);
      if_a.tens = t; if_a.ones = o;
      if_b.tens = t; if_b.ones = o;
   endtask

   task automatic test_reset();
      logic [1:0] exp_an;
      rst = 1'b1;
      set_pair(4'd0, 4'd0);
      tick();
      rst = 1'b0;
      checks++; if (if_a.an !== 2'b10) begin errors++; $display("FAIL reset_an_a: got %b expected 10", if_a.an); end
      checks++; if (if_a.seg !== 7'h40) begin errors++; $display("FAIL reset_seg_a: got %h expected 40", if_a.seg); end
      checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL reset_upd_a: got %b expected 0", if_a.disp_update); end
      checks++; if (if_a.scan_dbg !== 1'b0) begin errors++; $display("FAIL reset_state_a: got %b expected 0", if_a.scan_dbg); end
      checks++; if (if_b.an !== 2'b10) begin errors++; $display("FAIL reset_an_b: got %b expected 10", if_b.an); end
      checks++; if (if_b.seg !== 7'h40) begin errors++; $display("FAIL reset_seg_b: got %h expected 40", if_b.seg); end
      for (int k = 0; k < 12; k++) begin
         exp_an = (((scan_k / 4) % 2) == 1) ? 2'b01 : 2'b10;
         checks++; if (if_a.an !== exp_an) begin errors++; $display("FAIL scan_an_a k=%0d: got %b expected %b", k, if_a.an, exp_an); end
         exp_an = ((scan_k % 2) == 1) ? 2'b01 : 2'b10;
         checks++; if (if_b.an !== exp_an) begin errors++; $display("FAIL scan_an_b k=%0d: got %b expected %b", k, if_b.an, exp_an); end
         tick();
      end
   endtask

   task automatic test_accept();
      logic [6:0] exp_seg;
      set_pair(4'd1, 4'd5);
      tick(); // edge N
      checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_a_n0: got %b expected 0", if_a.disp_update); end
      checks++; if (if_b.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_b_n0: got %b expected 0", if_b.disp_update); end
      tick();
      checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_a_n1: got %b expected 0", if_a.disp_update); end
      checks++; if (if_b.disp_update !== 1'b1) begin errors++; $display("FAIL acc_upd_b_n1: got %b expected 1", if_b.disp_update); end
      tick();
      checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_a_n2: got %b expected 0", if_a.disp_update); end
      checks++; if (if_b.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_b_n2: got %b expected 0", if_b.disp_update); end
      tick();
      checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL acc_upd_a_n3: got %b expected 1", if_a.disp_update); end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL acc_upd_low k=%0d: got %b expected 0", k, if_a.disp_update); end
         end
         exp_seg = (((scan_k / 4) % 2) == 1) ? 7'h79 : 7'h12;
         checks++; if (if_a.seg !== exp_seg) begin errors++; $display("FAIL acc_seg_a k=%0d: got %h expected %h", k, if_a.seg, exp_seg); end
         exp_seg = ((scan_k % 2) == 1) ? 7'h79 : 7'h12;
         checks++; if (if_b.seg !== exp_seg) begin errors++; $display("FAIL acc_seg_b k=%0d: got %h expected %h", k, if_b.seg, exp_seg); end
         tick();
      end
   endtask

   task automatic test_glitch();
      logic [6:0] exp_seg;
      for (int i = 0; i < 10; i++) begin
         set_pair(4'd0, (i % 2 == 0) ? 4'd8 : 4'd7);
         for (int j = 0; j < 2; j++) begin
            tick();
            checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL glitch_upd i=%0d: got %b expected 0", i, if_a.disp_update); end
            exp_seg = (((scan_k / 4) % 2) == 1) ? 7'h79 : 7'h12;
            checks++; if (if_a.seg !== exp_seg) begin errors++; $display("FAIL glitch_seg i=%0d: got %h expected %h", i, if_a.seg, exp_seg); end
         end
      end
      set_pair(4'd0, 4'd8);
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL hold_upd_early j=%0d: got %b expected 0", j, if_a.disp_update); end
      end
      tick();
      checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL hold_upd: got %b expected 1", if_a.disp_update); end
      for (int k = 0; k < 8; k++) begin
         exp_seg = (((scan_k / 4) % 2) == 1) ? 7'h7F : 7'h00;
         checks++; if (if_a.seg !== exp_seg) begin errors++; $display("FAIL hold_seg k=%0d: got %h expected %h", k, if_a.seg, exp_seg); end
         tick();
      end
   endtask

   task automatic test_blank();
      logic [6:0] exp_seg;
      logic [1:0] exp_an;
      set_pair(4'd0, 4'd7);
      tick(); tick(); tick(); tick();
      checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL blank_upd: got %b expected 1", if_a.disp_update); end
      for (int k = 0; k < 8; k++) begin
         exp_seg = (((scan_k / 4) % 2) == 1) ? 7'h7F : 7'h78;
         exp_an  = (((scan_k / 4) % 2) == 1) ? 2'b01 : 2'b10;
         checks++; if (if_a.seg !== exp_seg) begin errors++; $display("FAIL blank_seg_a k=%0d: got %h expected %h", k, if_a.seg, exp_seg); end
         checks++; if (if_a.an !== exp_an) begin errors++; $display("FAIL blank_an_a k=%0d: got %b expected %b", k, if_a.an, exp_an); end
         exp_seg = ((scan_k % 2) == 1) ? 7'h40 : 7'h78;
         checks++; if (if_b.seg !== exp_seg) begin errors++; $display("FAIL noblank_seg_b k=%0d: got %h expected %h", k, if_b.seg, exp_seg); end
         tick();
      end
   endtask

   task automatic test_non_bcd();
      logic [3:0] t_tab [2] = '{4'd0, 4'hB};
      logic [3:0] o_tab [2] = '{4'hC, 4'd3};
      logic [6:0] ones_tab [2] = '{7'h3F, 7'h30};
      logic [6:0] tens_tab [2] = '{7'h7F, 7'h3F};
      logic [6:0] exp_seg;
      for (int v = 0; v < 2; v++) begin
         set_pair(t_tab[v], o_tab[v]);
         tick(); tick(); tick(); tick();
         checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL nbcd_upd v=%0d: got %b expected 1", v, if_a.disp_update); end
         for (int k = 0; k < 8; k++) begin
            exp_seg = (((scan_k / 4) % 2) == 1) ? tens_tab[v] : ones_tab[v];
            checks++; if (if_a.seg !== exp_seg) begin errors++; $display("FAIL nbcd_seg v=%0d k=%0d: got %h expected %h", v, k, if_a.seg, exp_seg); end
            tick();
         end
      end
   endtask

   task automatic test_repeat();
      set_pair(4'd5, 4'd5);
      tick();
      set_pair(4'hB, 4'd3);
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL repeat_upd_a k=%0d: got %b expected 0", k, if_a.disp_update); end
         checks++; if (if_b.disp_update !== 1'b0) begin errors++; $display("FAIL repeat_upd_b k=%0d: got %b expected 0", k, if_b.disp_update); end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      set_pair(4'd1, 4'd5);
      tick(); tick(); tick(); tick();
      checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL mid_pre_upd: got %b expected 1", if_a.disp_update); end
      for (int k = 0; k < 20 && !found; k++) begin
         if ((((scan_k / 4) % 2) == 1) && ((scan_k % 4) == 1)) found = 1'b1;
         else tick();
      end
      checks++; if (!found) begin errors++; $display("FAIL mid_wait_tens: got timeout expected tens slot"); end
      checks++; if (if_a.an !== 2'b01) begin errors++; $display("FAIL mid_an_tens: got %b expected 01", if_a.an); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (if_a.an !== 2'b10) begin errors++; $display("FAIL mid_an k=%0d: got %b expected 10", k, if_a.an); end
         checks++; if (if_a.seg !== 7'h40) begin errors++; $display("FAIL mid_seg k=%0d: got %h expected 40", k, if_a.seg); end
         checks++; if (if_a.disp_update !== 1'b0) begin errors++; $display("FAIL mid_upd k=%0d: got %b expected 0", k, if_a.disp_update); end
         tick();
      end
      checks++; if (if_a.disp_update !== 1'b1) begin errors++; $display("FAIL mid_reaccept_upd: got %b expected 1", if_a.disp_update); end
      checks++; if (if_a.an !== 2'b01) begin errors++; $display("FAIL mid_reaccept_an: got %b expected 01", if_a.an); end
      checks++; if (if_a.seg !== 7'h79) begin errors++; $display("FAIL mid_reaccept_seg: got %h expected 79", if_a.seg); end
   endtask

   initial begin
      set_pair(4'd0, 4'd0);
      test_reset();
      test_accept();
      test_glitch();
      test_blank();
      test_non_bcd();
      test_repeat();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
